// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: merges instruction-fetch (m0) and load/store (m1) traffic
// onto one port of the dual-port simulation RAM. Round-robin arbitration, an
// m1 lock for back-to-back beats, and routing of the 1-cycle read data back to
// the requester that issued the read.
// Optional statistics counters are built only when ARB_STATS_EN is defined;
// otherwise stat_grants_o and stat_stalls_o are tied to zero.
module ram_port_arbiter #(
    parameter int MEM_WIDTH = 65536,
    parameter int RR_START  = 0,
    localparam int AW       = $clog2(MEM_WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req_i,
    output logic          m0_gnt_o,
    input  logic [3:0]    m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [31:0]   m0_wdata_i,
    output logic          m0_rvalid_o,
    output logic [31:0]   m0_rdata_o,
    input  logic          m1_req_i,
    output logic          m1_gnt_o,
    input  logic [3:0]    m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [31:0]   m1_wdata_i,
    output logic          m1_rvalid_o,
    output logic [31:0]   m1_rdata_o,
    input  logic          m1_lock_i,
    output logic          ram_en_o,
    output logic [3:0]    ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_data_o,
    input  logic [31:0]   ram_data_i,
    output logic [31:0]   stat_grants_o,
    output logic [31:0]   stat_stalls_o
);

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    owner_e prio_q, prio_d;
    logic   lock_q, lock_d;
    logic   pend_valid_q, pend_valid_d;
    owner_e pend_id_q, pend_id_d;
    logic   accept;

    // Grant selection: a held lock beats priority, otherwise round-robin; no grants in reset
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (reset_n) begin
            if (m1_req_i && (lock_q || !m0_req_i || prio_q == OWNER_M1)) begin
                m1_gnt_o = 1'b1;
            end else if (m0_req_i) begin
                m0_gnt_o = 1'b1;
            end
        end
    end

    assign accept   = m0_gnt_o | m1_gnt_o;
    assign ram_en_o = accept;

    // RAM request mux: forward the winner's command, drive zeros when idle
    always_comb begin
        ram_we_o   = 4'b0;
        ram_addr_o = '0;
        ram_data_o = 32'b0;
        if (m0_gnt_o) begin
            ram_we_o   = m0_we_i;
            ram_addr_o = m0_addr_i;
            ram_data_o = m0_wdata_i;
        end else if (m1_gnt_o) begin
            ram_we_o   = m1_we_i;
            ram_addr_o = m1_addr_i;
            ram_data_o = m1_wdata_i;
        end
    end

    // Next-state: rotate priority after an accept, track lock and the pending read owner
    always_comb begin
        prio_d       = prio_q;
        lock_d       = lock_q & m1_lock_i;
        pend_valid_d = accept && (ram_we_o == 4'b0);
        pend_id_d    = m1_gnt_o ? OWNER_M1 : OWNER_M0;
        if (m0_gnt_o) begin
            prio_d = OWNER_M1;
        end else if (m1_gnt_o) begin
            prio_d = OWNER_M0;
        end
        if (m1_gnt_o) begin
            lock_d = m1_lock_i;
        end
    end

    // Arbitration state registers; reset also drops any read still in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q       <= (RR_START != 0) ? OWNER_M1 : OWNER_M0;
            lock_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= OWNER_M0;
        end else begin
            prio_q       <= prio_d;
            lock_q       <= lock_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
        end
    end

    // Read return: steer the RAM's registered data to the owner, zero for the other side
    always_comb begin
        m0_rvalid_o = pend_valid_q && (pend_id_q == OWNER_M0);
        m1_rvalid_o = pend_valid_q && (pend_id_q == OWNER_M1);
        m0_rdata_o  = m0_rvalid_o ? ram_data_i : 32'b0;
        m1_rdata_o  = m1_rvalid_o ? ram_data_i : 32'b0;
    end

`ifdef ARB_STATS_EN
    logic [31:0] grants_q, grants_d;
    logic [31:0] stalls_q, stalls_d;

    // Counter increments: one per accept, one per cycle where any requester waits
    always_comb begin
        grants_d = grants_q;
        stalls_d = stalls_q;
        if (accept) begin
            grants_d = grants_q + 32'd1;
        end
        if ((m0_req_i && !m0_gnt_o) || (m1_req_i && !m1_gnt_o)) begin
            stalls_d = stalls_q + 32'd1;
        end
    end

    // Statistics registers, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grants_q <= 32'd0;
            stalls_q <= 32'd0;
        end else begin
            grants_q <= grants_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_grants_o = grants_q;
    assign stat_stalls_o = stalls_q;
`else
    assign stat_grants_o = 32'd0;
    assign stat_stalls_o = 32'd0;
`endif

endmodule
